// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, word address and the memory-stage state.
package cpu_types_pkg;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned WADDR_W = 30;

   typedef logic [WORD_W-1:0]  word_t;
   typedef logic [WADDR_W-1:0] waddr_t;

   typedef enum logic {IDLE = 1'b0, DONE = 1'b1} memstate_t;

   // Word address (byte offset dropped) used for link tracking.
   function automatic waddr_t word_addr(input word_t a);
      return a[WORD_W-1:2];
   endfunction
endpackage

// File: rtl/ll_sc_link.sv
// Load-linked reservation: link register, snoop compare and SC link check.
module ll_sc_link
   import cpu_types_pkg::*;
(
   input  logic               clk,
   input  logic               nRst,
   input  logic               ll_set,
   input  logic               sc_clr,
   input  logic               snoop_inv,
   input  logic [WORD_W-1:0]  set_addr,
   input  logic [WORD_W-1:0]  snoop_addr,
   input  logic [WORD_W-1:0]  chk_addr,
   output logic               link_valid,
   output logic [WADDR_W-1:0] link_addr,
   output logic               link_ok_c
);
   logic   link_valid_q, link_valid_d;
   waddr_t link_addr_q,  link_addr_d;
   logic   snoop_hit_c;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
      end else begin
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
      end
   end

   // A snoop to the linked word kills the link in the same cycle it arrives.
   always_comb begin
      snoop_hit_c = snoop_inv & (word_addr(snoop_addr) == link_addr_q);
      link_ok_c   = link_valid_q & (link_addr_q == word_addr(chk_addr)) & !snoop_hit_c;
   end

   // A completing LL re-arms the link even against a coincident snoop.
   always_comb begin
      link_valid_d = link_valid_q;
      link_addr_d  = link_addr_q;
      if (ll_set) begin
         link_valid_d = 1'b1;
         link_addr_d  = word_addr(set_addr);
      end else if (sc_clr | snoop_hit_c) begin
         link_valid_d = 1'b0;
      end
   end

   assign link_valid = link_valid_q;
   assign link_addr  = link_addr_q;
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues dcache requests, stalls the pipe,
// holds results while the pipe is frozen and resolves LL/SC.
module mem_access_ctrl
   import cpu_types_pkg::*;
(
   input  logic              clk,
   input  logic              nRst,
   input  logic              advance,
   input  logic              op_valid,
   input  logic              ren_in,
   input  logic              wen_in,
   input  logic              ll_in,
   input  logic              sc_in,
   input  logic [WORD_W-1:0] addr_in,
   input  logic [WORD_W-1:0] store_in,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dcache_load,
   input  logic              snoop_inv,
   input  logic [WORD_W-1:0] snoop_addr,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic [WORD_W-1:0] dmemload_out,
   output logic [WORD_W-1:0] port_O_out,
   output logic              link_valid
);
   memstate_t state_q, state_d;
   word_t     load_q,  load_d;
   logic      sc_q,    sc_d;

   logic   mem_op_c, req_c, complete_c, sc_res_c, link_ok_c;
   waddr_t link_addr_unused;

   ll_sc_link u_link (
      .clk        (clk),
      .nRst       (nRst),
      .ll_set     (complete_c & ll_in),
      .sc_clr     (complete_c & sc_in),
      .snoop_inv  (snoop_inv),
      .set_addr   (addr_in),
      .snoop_addr (snoop_addr),
      .chk_addr   (addr_in),
      .link_valid (link_valid),
      .link_addr  (link_addr_unused),
      .link_ok_c  (link_ok_c)
   );

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= IDLE;
         load_q  <= '0;
         sc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
         sc_q    <= sc_d;
      end
   end

   assign mem_op_c = op_valid & (ren_in | wen_in | ll_in | sc_in);

   // A failed SC has no request, so it completes immediately with result 0.
   always_comb begin
      state_d      = state_q;
      load_d       = load_q;
      sc_d         = sc_q;
      dmemREN      = 1'b0;
      dmemWEN      = 1'b0;
      req_c        = 1'b0;
      mem_stall    = 1'b0;
      complete_c   = 1'b0;
      sc_res_c     = 1'b0;
      dmemaddr     = addr_in;
      dmemstore    = store_in;
      dmemload_out = dcache_load;
      port_O_out   = addr_in;
      case (state_q)
         IDLE: begin
            if (mem_op_c) begin
               dmemREN    = ren_in | ll_in;
               dmemWEN    = wen_in | (sc_in & link_ok_c);
               req_c      = (ren_in | ll_in) | wen_in | (sc_in & link_ok_c);
               complete_c = req_c ? dhit : 1'b1;
               mem_stall  = req_c & !dhit;
               sc_res_c   = sc_in & link_ok_c & dhit;
               if (sc_in) port_O_out = WORD_W'(sc_res_c);
               if (complete_c & !advance) begin
                  state_d = DONE;
                  load_d  = dcache_load;
                  sc_d    = sc_res_c;
               end
            end
         end
         DONE: begin
            dmemload_out = load_q;
            if (op_valid & sc_in) port_O_out = WORD_W'(sc_q);
            if (advance) state_d = IDLE;
         end
      endcase
   end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; nRst  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: advance  in  1  hazard-unit pipeline enable, drives memwb wen; op_valid  in  1  EX/MEM holds a live instruction.
REQ-003 SHALL have ports: ren_in  in  1  load; wen_in  in  1  store; ll_in  in  1  load-linked; sc_in  in  1  store-conditional.
REQ-004 SHALL have ports: addr_in  in  32  EX/MEM port_O, the effective address; store_in  in  32  store data.
REQ-005 SHALL have ports: dhit  in  1  dcache done; dcache_load  in  32  dcache read data.
REQ-006 SHALL have ports: snoop_inv  in  1  other core invalidates a line; snoop_addr  in  32  address of that line.
REQ-007 SHALL have ports: dmemREN  out  1; dmemWEN  out  1; dmemaddr  out  32; dmemstore  out  32.
REQ-008 SHALL have ports: mem_stall  out  1  freeze all upstream stages; dmemload_out  out  32  to memwb dmemload_input.
REQ-009 SHALL have ports: port_O_out  out  32  to memwb port_O_input; link_valid  out  1  debug.

Function
REQ-010 SHALL implement the FSM states IDLE and DONE.
REQ-011 IDLE, mem op present (op_valid & (ren|wen|ll|sc)): SHALL drive dmemaddr=addr_in and dmemstore=store_in, and assert the request combinationally in the same cycle.
REQ-012 Request SHALL be dmemREN for ren|ll, and dmemWEN for wen, and dmemWEN for sc only when link_ok.
REQ-013 link_ok SHALL equal link_valid & link_addr==addr_in[31:2] & !(snoop_inv & snoop_addr[31:2]==link_addr).
REQ-014 mem_stall SHALL equal request & !dhit while in IDLE; it SHALL be 0 in DONE and when no op is present.
REQ-015 IDLE, dhit & advance: SHALL stay IDLE, with dmemload_out=dcache_load (zero added latency).
REQ-016 IDLE, dhit & !advance: SHALL go to DONE and capture dcache_load into load_q and the SC result into sc_q.
REQ-017 DONE: SHALL deassert all requests, so the op is never reissued, drive dmemload_out=load_q, and return to IDLE on advance.
REQ-018 SC with !link_ok: SHALL complete in 0 wait cycles, issue no write, and produce result 0.
REQ-019 SC with link_ok: SHALL produce result 1 on dhit.
REQ-020 SC: port_O_out SHALL be {31'b0,result}, taken from sc_q while in DONE. Otherwise port_O_out SHALL pass addr_in.
REQ-021 If the link is lost during an SC wait, WEN SHALL drop that cycle and the SC SHALL fail.
REQ-022 LL completion (dhit) SHALL set link_valid=1 and link_addr=addr_in[31:2].
REQ-023 Any SC completion SHALL clear link_valid.
REQ-024 A snoop_inv whose address matches link_addr SHALL clear link_valid.
REQ-025 Snoop and LL completion in the same cycle: LL set SHALL win.
REQ-026 A local plain store to link_addr SHALL NOT clear the link.
REQ-027 op_valid=0 SHALL assert no request and cause no state change, except snoop handling.

Reset
REQ-028 nRst low SHALL asynchronously force: state=IDLE, link_valid=0, link_addr=0, load_q=0, sc_q=0.
REQ-029 Reset during a pending access SHALL abandon it, and combinational outputs SHALL then reflect the inputs.

Structure
REQ-030 word_t and the memstate_t enum {IDLE,DONE} SHALL live in cpu_types_pkg.
REQ-031 The link register, the snoop compare and link_ok SHALL be a sub-module ll_sc_link.

Verification
REQ-032 LW addr 0x100, dhit after 3 cycles, advance=1 -> mem_stall high 3 cycles, dmemload_out=dcache_load on the dhit cycle, one REN burst only.
REQ-033 SW with dhit while advance=0 for 2 cycles -> DONE entered, dmemWEN low both cycles, IDLE on advance.
REQ-034 LL 0x200 then SC 0x200, no snoop -> WEN issued, port_O_out=1, link_valid=0 afterwards.
REQ-035 LL 0x200, snoop_inv 0x204 (same word 0x200>>2? no: different word) then SC -> success. Then LL 0x200, snoop_inv 0x200, SC -> no WEN, port_O_out=0, mem_stall=0.
REQ-036 LL dhit and matching snoop in the same cycle -> link_valid=1. Reset asserted mid-SC wait -> link_valid=0, state IDLE.
